// File: rtl/cmos_window_packer.sv
// cmos_window_packer
//   Takes the synchronised RGB565 stream from the CMOS capture stage and
//   tracks x/y pixel coordinates. It crops a programmable window and packs
//   each pair of window pixels into one 32-bit word. The words are queued in
//   a first-word-fall-through FIFO that the frame-buffer writer reads through
//   a valid/ready port.
//
// Ports
//   cmos_pclk         pixel clock, the only clock
//   sys_rst           synchronous reset, active-high
//   cmos_frame_vsync  frame sync; a falling edge starts a frame
//   cmos_frame_href   line valid; a falling edge ends a line
//   cmos_frame_data   RGB565 pixel {R[4:0],G[5:0],B[4:0]}
//   cmos_frame_clken  pixel strobe; a pixel is taken when clken & href
//   out_valid         FIFO head word is valid
//   out_ready         consumer takes the head word when out_valid & out_ready
//   out_data          {first pixel, second pixel}; 0 when !out_valid
//   out_sof           head word is the first word of a frame window
//   out_eol           head word is the last word of a window line
//   frame_done        one-cycle pulse when the last window word enters the FIFO
//   ovf_flag          sticky; a word was lost because the FIFO was full

module cmos_window_packer #(
   parameter int H_START    = 0,
   parameter int V_START    = 0,
   parameter int WIN_W      = 640,
   parameter int WIN_H      = 480,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        cmos_pclk,
   input  logic        sys_rst,
   input  logic        cmos_frame_vsync,
   input  logic        cmos_frame_href,
   input  logic [15:0] cmos_frame_data,
   input  logic        cmos_frame_clken,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_sof,
   output logic        out_eol,
   output logic        frame_done,
   output logic        ovf_flag
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [11:0] X_LO   = 12'(H_START);
   localparam logic [11:0] X_HI   = 12'(H_START + WIN_W);
   localparam logic [11:0] X_LAST = 12'(H_START + WIN_W - 1);
   localparam logic [11:0] Y_LO   = 12'(V_START);
   localparam logic [11:0] Y_HI   = 12'(V_START + WIN_H);
   localparam logic [11:0] Y_LAST = 12'(V_START + WIN_H - 1);

   typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;

   state_t state, state_next;

   logic        vsync_d, href_d;
   logic        frame_start, line_end;
   logic [11:0] x, y, x_inc, y_inc;
   logic        sof_pending;
   logic [15:0] hold;
   logic        pix_acc, win_hit, odd_col, word_push;

   logic        stg_valid, stg_sof, stg_eol, stg_last;
   logic [31:0] stg_data;

   logic [33:0] mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr, count;
   logic        full, empty, pop, lost, wr_en;
   logic [33:0] head;

   // Reset the sync copies low so that a low vsync right after reset
   // cannot be mistaken for a frame start.
   always_ff @(posedge cmos_pclk) begin
      if (sys_rst) begin
         vsync_d <= 1'b0;
         href_d  <= 1'b0;
      end else begin
         vsync_d <= cmos_frame_vsync;
         href_d  <= cmos_frame_href;
      end
   end

   assign frame_start = vsync_d & ~cmos_frame_vsync;
   assign line_end    = href_d & ~cmos_frame_href;

   // A frame start takes priority over any pixel on the same cycle.
   assign pix_acc   = (state == ACTIVE) && cmos_frame_clken && cmos_frame_href && !frame_start;
   assign win_hit   = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
   assign odd_col   = x[0] ^ X_LO[0];
   assign word_push = pix_acc && win_hit && odd_col;

   assign x_inc = (x == 12'hFFF) ? x : x + 12'd1;
   assign y_inc = (y == 12'hFFF) ? y : y + 12'd1;

   // Column parity comes from x, so clearing x at line end is enough to
   // drop a half-filled word; hold is zeroed only to keep state tidy.
   always_ff @(posedge cmos_pclk) begin
      if (sys_rst) begin
         x           <= '0;
         y           <= '0;
         hold        <= '0;
         sof_pending <= 1'b0;
      end else if (frame_start) begin
         x           <= '0;
         y           <= '0;
         hold        <= '0;
         sof_pending <= 1'b1;
      end else begin
         if (line_end) begin
            x    <= '0;
            y    <= y_inc;
            hold <= '0;
         end else if (pix_acc) begin
            x <= x_inc;
            if (win_hit && !odd_col) hold <= cmos_frame_data;
         end
         if (word_push) sof_pending <= 1'b0;
      end
   end

   // One register stage between packing and the FIFO write.
   always_ff @(posedge cmos_pclk) begin
      if (sys_rst) begin
         stg_valid <= 1'b0;
         stg_sof   <= 1'b0;
         stg_eol   <= 1'b0;
         stg_last  <= 1'b0;
         stg_data  <= '0;
      end else begin
         stg_valid <= word_push;
         if (word_push) begin
            stg_sof  <= sof_pending;
            stg_eol  <= (x == X_LAST);
            stg_last <= (x == X_LAST) && (y == Y_LAST);
            stg_data <= {hold, cmos_frame_data};
         end
      end
   end

   assign count = wr_ptr - rd_ptr;
   assign full  = (count == (AW+1)'(FIFO_DEPTH));
   assign empty = (count == '0);
   assign pop   = out_valid && out_ready;
   // A pop on the same edge frees the slot, so a full FIFO still accepts.
   assign lost  = stg_valid && full && !pop;
   assign wr_en = stg_valid && !lost;

   always_comb begin
      state_next = state;
      if (frame_start) begin
         state_next = ACTIVE;
      end else begin
         case (state)
            ACTIVE: begin
               if (lost)                          state_next = DROP;
               else if (line_end && y_inc == Y_HI) state_next = IDLE;
            end
            default: state_next = state;
         endcase
      end
   end

   always_ff @(posedge cmos_pclk) begin
      if (sys_rst) state <= IDLE;
      else         state <= state_next;
   end

   always_ff @(posedge cmos_pclk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= {stg_sof, stg_eol, stg_data};
   end

   always_ff @(posedge cmos_pclk) begin
      if (sys_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         ovf_flag   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         if (lost)  ovf_flag <= 1'b1;
         frame_done <= wr_en && stg_last;
      end
   end

   assign head      = mem[rd_ptr[AW-1:0]];
   assign out_valid = !empty;
   assign out_data  = out_valid ? head[31:0] : 32'd0;
   assign out_sof   = out_valid && head[33];
   assign out_eol   = out_valid && head[32];

endmodule
